// File: rtl/logo_scroll_painter.sv
// Paints NUM_GLYPHS side-by-side "T" glyphs at a per-frame scrolling offset.
// The hit and hit_glyph outputs are registered, giving one clock of latency from x/y/enble.
module logo_scroll_painter #(
  parameter int W            = 11,
  parameter int NUM_GLYPHS   = 3,
  parameter int GIDX_W       = 3,
  parameter int BASE_X       = 500,
  parameter int BASE_Y       = 550,
  parameter int PITCH        = 40,
  parameter int BAR_OFF      = 10,
  parameter int BAR_W        = 20,
  parameter int BAR_H        = 5,
  parameter int STEM_OFF     = 20,
  parameter int STEM_W       = 5,
  parameter int STEM_H       = 40,
  parameter int MIN_DELT     = 0,
  parameter int MAX_DELT     = 300,
  parameter int STEP         = 2,
  parameter int BLINK_FRAMES = 30
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enble,
  input  logic              frame_start,
  input  logic [1:0]        mode,
  input  logic [W-1:0]      x,
  input  logic [W-1:0]      y,
  output logic              hit,
  output logic [GIDX_W-1:0] hit_glyph,
  output logic [W-1:0]      delt
);

  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES + 1) : 1;

  localparam logic [W:0] BASE_X_E   = (W+1)'(BASE_X);
  localparam logic [W:0] BASE_Y_E   = (W+1)'(BASE_Y);
  localparam logic [W:0] BAR_OFF_E  = (W+1)'(BAR_OFF);
  localparam logic [W:0] BAR_W_E    = (W+1)'(BAR_W);
  localparam logic [W:0] BAR_H_E    = (W+1)'(BAR_H);
  localparam logic [W:0] STEM_OFF_E = (W+1)'(STEM_OFF);
  localparam logic [W:0] STEM_W_E   = (W+1)'(STEM_W);
  localparam logic [W:0] STEM_H_E   = (W+1)'(STEM_H);
  localparam logic [W:0] MIN_E      = (W+1)'(MIN_DELT);
  localparam logic [W:0] MAX_E      = (W+1)'(MAX_DELT);
  localparam logic [W:0] STEP_E     = (W+1)'(STEP);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  logic [W-1:0]      delt_q, delt_d;
  logic              dir_q, dir_d;
  logic              visible_q, visible_d;
  logic [BW-1:0]     blink_q, blink_d;
  logic              hit_q;
  logic [GIDX_W-1:0] hit_glyph_q;

  logic              any_s;
  logic [GIDX_W-1:0] first_s;
  logic              paint_s;

  // Region test for every glyph against the offset held before this edge's update.
  always_comb begin
    logic [W:0] xe, ye, ox, bx0, sx0;
    logic       ybar, ystem, bar_hit, stem_hit;
    xe      = {1'b0, x};
    ye      = {1'b0, y};
    ybar    = (ye >= BASE_Y_E) && (ye < BASE_Y_E + BAR_H_E);
    ystem   = (ye >= BASE_Y_E) && (ye < BASE_Y_E + STEM_H_E);
    any_s   = 1'b0;
    first_s = {GIDX_W{1'b0}};
    ox      = {(W+1){1'b0}};
    bx0     = {(W+1){1'b0}};
    sx0     = {(W+1){1'b0}};
    bar_hit  = 1'b0;
    stem_hit = 1'b0;
    // Descending scan so the lowest-numbered glyph is the last writer.
    for (int g = NUM_GLYPHS - 1; g >= 0; g--) begin
      ox       = BASE_X_E + {1'b0, delt_q} + (W+1)'(g * PITCH);
      bx0      = ox + BAR_OFF_E;
      sx0      = ox + STEM_OFF_E;
      bar_hit  = ybar  && (xe >= bx0) && (xe < bx0 + BAR_W_E);
      stem_hit = ystem && (xe >= sx0) && (xe < sx0 + STEM_W_E);
      if (bar_hit || stem_hit) begin
        any_s   = 1'b1;
        first_s = GIDX_W'(g);
      end else begin
        any_s   = any_s;
      end
    end
  end

  assign paint_s = enble & visible_q & any_s;

  // Per-frame offset, direction and blink state update.
  always_comb begin
    logic [W:0] cur, up;
    cur       = {1'b0, delt_q};
    up        = cur + STEP_E;
    delt_d    = delt_q;
    dir_d     = dir_q;
    visible_d = visible_q;
    blink_d   = blink_q;
    if (frame_start) begin
      case (mode)
        2'b00: begin
          blink_d   = {BW{1'b0}};
          visible_d = 1'b1;
        end
        2'b01: begin
          blink_d   = {BW{1'b0}};
          visible_d = 1'b1;
          if (up > MAX_E) begin
            delt_d = W'(MIN_E);
          end else begin
            delt_d = W'(up);
          end
        end
        2'b10: begin
          blink_d   = {BW{1'b0}};
          visible_d = 1'b1;
          if (dir_q == DIR_UP) begin
            if (up >= MAX_E) begin
              delt_d = W'(MAX_E);
              dir_d  = DIR_DOWN;
            end else begin
              delt_d = W'(up);
            end
          end else begin
            if (cur <= MIN_E + STEP_E) begin
              delt_d = W'(MIN_E);
              dir_d  = DIR_UP;
            end else begin
              delt_d = W'(cur - STEP_E);
            end
          end
        end
        2'b11: begin
          if (blink_q == BLINK_LAST) begin
            blink_d   = {BW{1'b0}};
            visible_d = ~visible_q;
          end else begin
            blink_d   = blink_q + BW'(1);
          end
        end
        default: begin
          delt_d = delt_q;
        end
      endcase
      // A corrupted offset is pulled back into range on the next strobe.
      if ((cur < MIN_E) || (cur > MAX_E)) begin
        delt_d = W'(MIN_E);
      end else begin
        delt_d = delt_d;
      end
    end else begin
      delt_d = delt_q;
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      delt_q      <= W'(MIN_E);
      dir_q       <= DIR_UP;
      visible_q   <= 1'b1;
      blink_q     <= {BW{1'b0}};
      hit_q       <= 1'b0;
      hit_glyph_q <= {GIDX_W{1'b0}};
    end else begin
      delt_q      <= delt_d;
      dir_q       <= dir_d;
      visible_q   <= visible_d;
      blink_q     <= blink_d;
      hit_q       <= paint_s;
      hit_glyph_q <= paint_s ? first_s : {GIDX_W{1'b0}};
    end
  end

  assign hit       = hit_q;
  assign hit_glyph = hit_glyph_q;
  assign delt      = delt_q;

endmodule

// File: tb/tb_logo_scroll_painter.sv
// Directed bench for logo_scroll_painter: geometry vector table plus wrap, bounce,
// blink and mid-operation reset sequences with hand-computed expectations.
module tb_logo_scroll_painter;

  localparam int W      = 11;
  localparam int GIDX_W = 3;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              enble = 1'b0;
  logic              frame_start = 1'b0;
  logic [1:0]        mode = 2'b00;
  logic [W-1:0]      x = '0;
  logic [W-1:0]      y = '0;
  logic              hit;
  logic [GIDX_W-1:0] hit_glyph;
  logic [W-1:0]      delt;

  int nvec = 0;
  int nerr = 0;

  logo_scroll_painter dut (
    .clk(clk), .rst(rst), .enble(enble), .frame_start(frame_start), .mode(mode),
    .x(x), .y(y), .hit(hit), .hit_glyph(hit_glyph), .delt(delt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] vx;
    logic [W-1:0] vy;
    logic         ven;
    logic         ehit;
    logic [2:0]   eglyph;
  } vec_t;

  vec_t vecs[15];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input int n);
    frame_start = 1'b1;
    repeat (n) step();
    frame_start = 1'b0;
  endtask

  initial begin
    // Geometry at delt=0: glyph g origin 500+40g, bar x 510..529 y 550..554, stem x 520..524 y 550..589.
    vecs[0]  = '{11'd515, 11'd552, 1'b1, 1'b1, 3'd0};
    vecs[1]  = '{11'd530, 11'd552, 1'b1, 1'b0, 3'd0};
    vecs[2]  = '{11'd522, 11'd589, 1'b1, 1'b1, 3'd0};
    vecs[3]  = '{11'd522, 11'd590, 1'b1, 1'b0, 3'd0};
    vecs[4]  = '{11'd560, 11'd560, 1'b1, 1'b1, 3'd1};
    vecs[5]  = '{11'd600, 11'd551, 1'b1, 1'b1, 3'd2};
    vecs[6]  = '{11'd600, 11'd551, 1'b0, 1'b0, 3'd0};
    vecs[7]  = '{11'd510, 11'd550, 1'b1, 1'b1, 3'd0};
    vecs[8]  = '{11'd509, 11'd550, 1'b1, 1'b0, 3'd0};
    vecs[9]  = '{11'd529, 11'd554, 1'b1, 1'b1, 3'd0};
    vecs[10] = '{11'd529, 11'd555, 1'b1, 1'b0, 3'd0};
    vecs[11] = '{11'd524, 11'd589, 1'b1, 1'b1, 3'd0};
    vecs[12] = '{11'd525, 11'd570, 1'b1, 1'b0, 3'd0};
    vecs[13] = '{11'd640, 11'd580, 1'b1, 1'b0, 3'd0};
    vecs[14] = '{11'd602, 11'd549, 1'b1, 1'b0, 3'd0};

    enble = 1'b1;
    x = 11'd515;
    y = 11'd552;
    step();
    step();
    chk("reset_hit", hit, 1'b0);
    chk("reset_glyph", hit_glyph, 3'd0);
    chk("reset_delt", delt, 11'd0);

    rst = 1'b1;
    mode = 2'b00;
    pulse(1);
    chk("static_delt", delt, 11'd0);

    for (int i = 0; i < 15; i++) begin
      x = vecs[i].vx;
      y = vecs[i].vy;
      enble = vecs[i].ven;
      step();
      chk($sformatf("vec%0d_hit", i), hit, vecs[i].ehit);
      chk($sformatf("vec%0d_glyph", i), hit_glyph, vecs[i].eglyph);
    end
    enble = 1'b1;

    // Wrap scroll: 150 strobes reach 300, the next wraps to 0.
    mode = 2'b01;
    pulse(150);
    chk("wrap_top", delt, 11'd300);
    x = 11'd815;
    y = 11'd552;
    step();
    chk("wrap_top_hit", hit, 1'b1);
    chk("wrap_top_glyph", hit_glyph, 3'd0);
    pulse(1);
    chk("wrap_zero", delt, 11'd0);

    // Bounce: up to 300, turn, down to 0, turn.
    mode = 2'b10;
    pulse(150);
    chk("bounce_top", delt, 11'd300);
    pulse(1);
    chk("bounce_down1", delt, 11'd298);
    pulse(149);
    chk("bounce_bottom", delt, 11'd0);
    pulse(1);
    chk("bounce_up_again", delt, 11'd2);

    // Blink at delt=2: bar spans x 512..531, so x=515 is on glyph 0.
    mode = 2'b11;
    x = 11'd515;
    y = 11'd552;
    for (int f = 0; f <= 60; f++) begin
      step();
      chk($sformatf("blink_f%0d", f), hit, (f < 30 || f >= 60) ? 1'b1 : 1'b0);
      if (f < 60) pulse(1);
    end
    chk("blink_delt_held", delt, 11'd2);
    pulse(30);
    step();
    chk("blink_hidden", hit, 1'b0);
    mode = 2'b00;
    step();
    chk("mode_change_pending", hit, 1'b0);
    pulse(1);
    step();
    chk("static_visible", hit, 1'b1);

    // Reset during bounce: 2 -> 300 in 149 strobes, then 90 down to 120.
    mode = 2'b10;
    pulse(149);
    chk("pre_reset_top", delt, 11'd300);
    pulse(90);
    chk("pre_reset_delt", delt, 11'd120);
    rst = 1'b0;
    frame_start = 1'b1;
    step();
    rst = 1'b1;
    frame_start = 1'b0;
    chk("midreset_delt", delt, 11'd0);
    chk("midreset_hit", hit, 1'b0);
    pulse(1);
    chk("midreset_dir_up", delt, 11'd2);
    step();
    chk("midreset_hit_resume", hit, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
